// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and constants for the iterative square-root controller.
package sqrt_pkg;
  localparam int SQRT_WIDTH = 16;
  localparam int SQRT_ITER  = SQRT_WIDTH / 2;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;
  typedef struct packed {
    logic load_a;
    logic clr_r;
    logic shift_a;
    logic load_r;
    logic load_q0;
    logic q_bit;
  } strobe_t;
endpackage

// File: rtl/sqrt_iter_cnt.sv
// sqrt_iter_cnt: digit-iteration counter that saturates at the last iteration.
module sqrt_iter_cnt #(
  parameter int ITER  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == CNT_W'(ITER - 1);
  assign cnt_d  = clr_i ? '0 : (inc_i && !last_o) ? cnt_q + CNT_W'(1) : cnt_q;
  assign cnt_o  = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sequences load/shift/root-bit insertion of the iterative integer square root.
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH,
  parameter int ITER  = WIDTH / 2,
  parameter int CNT_W = $clog2(SQRT_ITER) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             ge_i,
  output logic             load_a_o,
  output logic             clr_r_o,
  output logic             shift_a_o,
  output logic             load_r_o,
  output logic             load_q0_o,
  output logic             q_bit_o,
  output logic [CNT_W-1:0] iter_o,
  output logic             busy_o,
  output logic             done_o
);
  state_e  state_q;
  strobe_t stb;
  logic    cmp, last;
  assign cmp = state_q == COMPARE;
  sqrt_iter_cnt #(.ITER(ITER), .CNT_W(CNT_W)) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q == LOAD),
    .inc_i  (cmp && !abort_i),
    .cnt_o  (iter_o),
    .last_o (last)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else
      case (state_q)
        IDLE:    state_q <= start_i ? LOAD : IDLE;
        LOAD:    state_q <= abort_i ? IDLE : SHIFT;
        SHIFT:   state_q <= abort_i ? IDLE : COMPARE;
        COMPARE: state_q <= abort_i ? IDLE : last ? DONE : SHIFT;
        default: state_q <= IDLE;
      endcase
  // Only the trial-subtract strobes look at ge; everything else is a pure state decode.
  always_comb
    stb = '{load_a:  state_q == LOAD,
            clr_r:   state_q == LOAD,
            shift_a: state_q == SHIFT,
            load_r:  cmp && ge_i,
            load_q0: cmp,
            q_bit:   cmp && ge_i};
  assign load_a_o  = stb.load_a;
  assign clr_r_o   = stb.clr_r;
  assign shift_a_o = stb.shift_a;
  assign load_r_o  = stb.load_r;
  assign load_q0_o = stb.load_q0;
  assign q_bit_o   = stb.q_bit;
  assign busy_o    = state_q == LOAD || state_q == SHIFT || cmp;
  assign done_o    = state_q == DONE;
endmodule

// File: tb/tb_sqrt_ctrl.sv
// tb_sqrt_ctrl: directed bench driving sqrt_ctrl with a behavioural radicand/root datapath.
module tb_sqrt_ctrl;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, ge;
  logic load_a, clr_r, shift_a, load_r, load_q0, q_bit, busy, done;
  logic [3:0] iter;
  logic [15:0] rad = 0, dp_a = 0;
  logic [17:0] dp_rem = 0;
  logic [7:0] dp_root = 0, qbits = 0;
  int lr_cnt, lq0_cnt, q1_cnt, done_cnt, busy_cnt, cyc, iter_first;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  sqrt_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .ge_i(ge),
    .load_a_o(load_a), .clr_r_o(clr_r), .shift_a_o(shift_a), .load_r_o(load_r),
    .load_q0_o(load_q0), .q_bit_o(q_bit), .iter_o(iter), .busy_o(busy), .done_o(done)
  );

  assign ge = dp_rem >= {9'd0, dp_root, 1'b1};

  always @(negedge clk) begin
    if (load_a) dp_a = rad;
    if (clr_r) begin dp_rem = 0; dp_root = 0; end
    if (shift_a) begin
      dp_rem = {dp_rem[15:0], dp_a[15:14]};
      dp_a = dp_a << 2;
      dp_root = dp_root << 1;
    end
    if (load_r) begin dp_rem = dp_rem - {9'd0, dp_root, 1'b1}; lr_cnt++; end
    if (load_q0) begin
      dp_root[0] = q_bit;
      qbits = {qbits[6:0], q_bit};
      lq0_cnt++;
      if (q_bit) q1_cnt++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    lr_cnt = 0; lq0_cnt = 0; q1_cnt = 0; done_cnt = 0; busy_cnt = 0; qbits = 0;
    cyc = 0; iter_first = -1;
  endtask

  task automatic run(input logic [15:0] r, input int p1, input int p2);
    tick();
    rad = r;
    clear_counts();
    start = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      cyc++;
      start = (cyc == p1) || (cyc == p2);
      if (cyc == 2) iter_first = iter;
      if (done) break;
    end
    start = 0;
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({load_a, clr_r, shift_a, load_r, load_q0, q_bit, busy, done} !== 8'h00 || iter !== 4'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got strobes=%b iter=%0d, want 00000000 iter=0",
               {load_a, clr_r, shift_a, load_r, load_q0, q_bit, busy, done}, iter);
    end
    tick();
    rst_n = 1;
    tick();
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_144();
    run(16'd144, 0, 0);
    nvec++;
    if (cyc !== 18 || done !== 1'b1) begin nerr++; $display("FAIL r144_latency: got cycle %0d done=%b want 18", cyc, done); end
    nvec++;
    if (qbits !== 8'b0000_1100) begin nerr++; $display("FAIL r144_qbits: got %b want 00001100", qbits); end
    nvec++;
    if (dp_root !== 8'd12) begin nerr++; $display("FAIL r144_root: got %0d want 12", dp_root); end
    nvec++;
    if (busy_cnt !== 17) begin nerr++; $display("FAIL r144_busy: got %0d want 17", busy_cnt); end
    nvec++;
    if (lr_cnt !== 2 || lq0_cnt !== 8) begin nerr++; $display("FAIL r144_pulses: got lr=%0d lq0=%0d want 2/8", lr_cnt, lq0_cnt); end
    nvec++;
    if (iter_first !== 0) begin nerr++; $display("FAIL r144_iter0: got %0d want 0", iter_first); end
    nvec++;
    if (iter !== 4'd7 || busy !== 1'b0) begin nerr++; $display("FAIL r144_done_state: got iter=%0d busy=%b want 7/0", iter, busy); end
    tick();
    nvec++;
    if (done !== 1'b0 || iter !== 4'd7) begin nerr++; $display("FAIL r144_done_pulse: got done=%b iter=%0d want 0/7", done, iter); end
  endtask

  task automatic test_ffff();
    run(16'hFFFF, 0, 0);
    repeat (3) tick();
    nvec++;
    if (lr_cnt !== 8 || lq0_cnt !== 8) begin nerr++; $display("FAIL ffff_pulses: got lr=%0d lq0=%0d want 8/8", lr_cnt, lq0_cnt); end
    nvec++;
    if (dp_root !== 8'd255) begin nerr++; $display("FAIL ffff_root: got %0d want 255", dp_root); end
    nvec++;
    if (done_cnt !== 1) begin nerr++; $display("FAIL ffff_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero();
    run(16'd0, 0, 0);
    nvec++;
    if (cyc !== 18 || done !== 1'b1) begin nerr++; $display("FAIL zero_latency: got cycle %0d done=%b want 18", cyc, done); end
    nvec++;
    if (lr_cnt !== 0 || lq0_cnt !== 8 || q1_cnt !== 0) begin
      nerr++;
      $display("FAIL zero_pulses: got lr=%0d lq0=%0d q1=%0d want 0/8/0", lr_cnt, lq0_cnt, q1_cnt);
    end
    nvec++;
    if (dp_root !== 8'd0) begin nerr++; $display("FAIL zero_root: got %0d want 0", dp_root); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    tick();
    rad = 16'd144;
    clear_counts();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      hit = load_q0 && iter == 4'd3;
    end
    nvec++;
    if (!hit) begin nerr++; $display("FAIL rstmid_reach: got no iter-3 COMPARE want one"); end
    #1 rst_n = 0;
    #1;
    nvec++;
    if ({load_a, clr_r, shift_a, load_r, load_q0, q_bit, busy, done} !== 8'h00 || iter !== 4'd0) begin
      nerr++;
      $display("FAIL rstmid_async: got strobes=%b iter=%0d want 00000000 iter=0",
               {load_a, clr_r, shift_a, load_r, load_q0, q_bit, busy, done}, iter);
    end
    tick();
    rst_n = 1;
    repeat (20) tick();
    nvec++;
    if (done_cnt !== 0) begin nerr++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
    run(16'd144, 0, 0);
    nvec++;
    if (cyc !== 18 || iter_first !== 0 || dp_root !== 8'd12) begin
      nerr++;
      $display("FAIL rstmid_rerun: got cycle=%0d iter0=%0d root=%0d want 18/0/12", cyc, iter_first, dp_root);
    end
  endtask

  task automatic test_start_ignored();
    run(16'd144, 5, 17);
    repeat (4) tick();
    nvec++;
    if (done_cnt !== 1 || busy !== 1'b0) begin nerr++; $display("FAIL start_ignored: got done=%0d busy=%b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    tick();
    rad = 16'd144;
    clear_counts();
    start = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cyc++;
      seen = done;
    end
    nvec++;
    if (cyc !== 18) begin nerr++; $display("FAIL b2b_first_done: got cycle %0d want 18", cyc); end
    tick();
    nvec++;
    if (load_a !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL b2b_idle_gap: got load_a=%b busy=%b want 0/0", load_a, busy); end
    tick();
    nvec++;
    if (load_a !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL b2b_reload: got load_a=%b busy=%b want 1/1", load_a, busy); end
    start = 0;
    abort = 1;
    tick();
    abort = 0;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_abort_load: got busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    bit hit = 0;
    tick();
    rad = 16'hFFFF;
    clear_counts();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      hit = shift_a && iter == 4'd5;
    end
    nvec++;
    if (!hit) begin nerr++; $display("FAIL abort_reach: got no iter-5 SHIFT want one"); end
    abort = 1;
    tick();
    abort = 0;
    nvec++;
    if (busy !== 1'b0 || shift_a !== 1'b0 || load_q0 !== 1'b0) begin
      nerr++;
      $display("FAIL abort_idle: got busy=%b shift=%b lq0=%b want 0/0/0", busy, shift_a, load_q0);
    end
    repeat (20) tick();
    nvec++;
    if (done_cnt !== 0) begin nerr++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    abort = 1;
    tick();
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL abort_in_idle: got busy=%b want 0", busy); end
    start = 1;
    tick();
    start = 0;
    abort = 0;
    nvec++;
    if (load_a !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL abort_start_wins: got load_a=%b busy=%b want 1/1", load_a, busy); end
    for (int i = 0; i < 30 && !done; i++) tick();
    nvec++;
    if (done !== 1'b1 || dp_root !== 8'd255) begin nerr++; $display("FAIL abort_recover: got done=%b root=%0d want 1/255", done, dp_root); end
  endtask

  initial begin
    test_reset();
    test_144();
    test_ffff();
    test_zero();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sqrt_ctrl.md
Name: sqrt_ctrl

Overview:
Control unit for the iterative 16-bit integer square-root datapath. It uses the radicand/remainder shift registers and the root shift register, and takes trial-subtract comparator status back from the datapath. It sequences load, shift and root-bit insertion over WIDTH/2 digit iterations. Upstream logic sees a start/busy/done handshake plus abort.

Parameters:
WIDTH, 16, radicand width; must be even
ITER, WIDTH/2, number of digit iterations (root width)
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W >= ITER

Ports:
clk  in  1  system clock; controller registers on rising edge
reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
start  in  1  request new root; sampled only in IDLE
abort  in  1  synchronous cancel; sampled in LOAD/SHIFT/COMPARE
ge  in  1  datapath status: partial remainder >= trial value (4*root+1)
load_a  out  1  load radicand into A register
clr_r  out  1  clear remainder and root registers
shift_a  out  1  shift two radicand MSBs into remainder; root shifts left 1
load_r  out  1  load remainder with (remainder - trial)
load_q0  out  1  write q_bit into root LSB
q_bit  out  1  root bit value for load_q0
iter  out  CNT_W  current iteration index
busy  out  1  high from LOAD through COMPARE
done  out  1  one-cycle pulse, result valid on root register

Behaviour:
- Reset (reset=0): state=IDLE, iter=0, all outputs 0, asynchronously. Reset mid-operation drops strobes at once; no done is produced.
- All outputs are registered/decoded from state only (Moore), except q_bit/load_r/load_q0, which come from state COMPARE and ge.
- The datapath samples strobes on the following falling edge of clk.
- IDLE: outputs 0. If start=1, go to LOAD.
- LOAD (1 cycle): load_a=1, clr_r=1, busy=1, iter<=0. Next state is SHIFT.
- SHIFT (1 cycle): shift_a=1, busy=1. Next state is COMPARE.
- COMPARE (1 cycle): busy=1, load_q0=1, q_bit=ge, load_r=ge.
  - If iter==ITER-1, next state is DONE.
  - Otherwise, iter<=iter+1 and next state is SHIFT.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE. iter holds ITER-1 until the next LOAD.
- Latency: start sampled at edge N, done high during cycle N+2+2*ITER (cycle 18 for WIDTH=16).
- start rules:
  - Ignored outside IDLE, including while busy or in DONE.
  - Held high continuously, it restarts on the cycle after DONE, giving back-to-back runs with 1 IDLE cycle between them.
- abort=1 in LOAD/SHIFT/COMPARE: next state IDLE, strobes 0 that cycle onward, no done. abort has priority over the COMPARE transition. abort is ignored in IDLE/DONE.
- abort and start both high in IDLE: start wins.
- ge is don't-care outside COMPARE.
- iter never wraps: the counter stops at ITER-1.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package sqrt_pkg:
  - state enum (IDLE, LOAD, SHIFT, COMPARE, DONE)
  - SQRT_WIDTH=16, SQRT_ITER=8
  - strobe bundle typedef {load_a, clr_r, shift_a, load_r, load_q0, q_bit}
- One sub-module is natural: sqrt_iter_cnt, holding the iteration counter with clr, inc and a last flag.

Test Plan:
- Radicand 144; behavioural datapath drives ge per iteration 0,0,0,0,1,1,0,0 -> q_bit pulses match that sequence, root=12 (0x0C), done exactly 18 cycles after start edge, busy high 17 cycles.
- Radicand 0xFFFF, ge=1 every COMPARE -> 8 load_r and 8 load_q0 pulses, root=255, single done pulse.
- reset driven low in iteration 3 COMPARE -> all outputs 0 before next clk edge; after release, start yields a full 18-cycle run with iter from 0.
- start pulsed again at cycles 5 and 17 of a run -> ignored; exactly one done; start held high -> second LOAD on cycle after DONE.
- abort=1 in iteration 5 SHIFT -> IDLE next cycle, no done, busy=0; abort with start high in IDLE -> LOAD entered.
- Radicand 0 with ge=0 throughout -> no load_r pulses, 8 load_q0 with q_bit=0, done at cycle 18.
